// File: rtl/apb_pkg.sv
// ============================================================================
// Module   : apb_pkg
// Brief    : Shared types and helpers for the APB controller subsystem.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // Slave-index field width; one bit minimum so the field always exists.
   function automatic int sel_bits_f(input int num_slaves);
      return (num_slaves > 1) ? $clog2(num_slaves) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ============================================================================
// Module   : apb_slave_mem
// Brief    : APB register-file slave with programmable wait states.
//            Optional out-of-range error response: APB_SLVERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int OFF_WIDTH   = 7,
   parameter int SLAVE_DEPTH = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [OFF_WIDTH-1:0]  offset,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr
);

   localparam int IDX_W = (SLAVE_DEPTH > 1) ? $clog2(SLAVE_DEPTH) : 1;
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
`ifdef APB_SLVERR_EN
   localparam logic SLVERR_OOR = 1'b1;
`else
   localparam logic SLVERR_OOR = 1'b0;
`endif

   logic [DATA_WIDTH-1:0] mem_q [SLAVE_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [SLAVE_DEPTH];
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  in_range;
   logic                  access;
   logic                  done;
   logic [IDX_W-1:0]      word;

   assign in_range = 32'(offset) < SLAVE_DEPTH;
   assign word     = offset[IDX_W-1:0];
   assign access   = psel & penable;
   assign pready   = psel & (cnt_q == CNT_W'(WAIT_CYCLES));
   assign done     = access & pready;
   assign prdata   = (psel && in_range) ? mem_q[word] : '0;
   assign pslverr  = SLVERR_OOR & done & ~in_range;

   always_comb begin
      cnt_d = '0;
      if (access && !pready) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      mem_d = mem_q;
      if (done && pwrite && in_range) begin
         mem_d[word] = pwdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         for (int i = 0; i < SLAVE_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         mem_q <= mem_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/apb_controller_wrapper.sv
// ============================================================================
// Module   : apb_controller_wrapper
// Brief    : Host-driven APB master FSM plus NUM_SLAVES register-file slaves.
//            Optional out-of-range error response: APB_SLVERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_controller_wrapper
   import apb_pkg::*;
#(
   parameter int NUM_SLAVES  = 2,
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int SLAVE_DEPTH = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  i_PCLK,
   input  logic                  i_PRESETn,
   input  logic                  i_req_valid,
   input  logic                  i_req_write,
   input  logic [ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_req_ready,
   output logic                  o_rsp_valid,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                  o_rsp_err,
   output logic [ADDR_WIDTH-1:0] o_PADDR,
   output logic                  o_PWRITE,
   output logic [DATA_WIDTH-1:0] o_PWDATA,
   output logic                  o_PENABLE,
   output logic [NUM_SLAVES-1:0] o_PSEL,
   output logic [DATA_WIDTH-1:0] o_PRDATA,
   output logic                  o_PREADY
);

   localparam int SEL_BITS  = sel_bits_f(NUM_SLAVES);
   localparam int OFF_WIDTH = ADDR_WIDTH - SEL_BITS;
`ifdef APB_SLVERR_EN
   localparam logic SLVERR_OOR = 1'b1;
`else
   localparam logic SLVERR_OOR = 1'b0;
`endif

   typedef struct packed {
      logic                  write;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } apb_req_t;

   apb_state_e            state_q, state_d;
   apb_req_t              req_q, req_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   logic [SEL_BITS-1:0]   slv_idx;
   logic                  idx_valid;
   logic [NUM_SLAVES-1:0] psel;
   logic                  penable;
   logic [DATA_WIDTH-1:0] slv_prdata [NUM_SLAVES];
   logic [NUM_SLAVES-1:0] slv_pready;
   logic [NUM_SLAVES-1:0] slv_pslverr;
   logic [DATA_WIDTH-1:0] bus_prdata;
   logic                  xfer_ready;
   logic [DATA_WIDTH-1:0] xfer_rdata;
   logic                  xfer_err;

   assign slv_idx   = req_q.addr[ADDR_WIDTH-1 -: SEL_BITS];
   assign idx_valid = 32'(slv_idx) < NUM_SLAVES;
   assign penable   = (state_q == ACCESS);

   always_comb begin
      psel = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         psel[i] = (state_q != IDLE) && (32'(slv_idx) == i);
      end
   end

   for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      apb_slave_mem #(
         .DATA_WIDTH  (DATA_WIDTH),
         .OFF_WIDTH   (OFF_WIDTH),
         .SLAVE_DEPTH (SLAVE_DEPTH),
         .WAIT_CYCLES (WAIT_CYCLES)
      ) u_slave (
         .clk     (i_PCLK),
         .rst_n   (i_PRESETn),
         .psel    (psel[gi]),
         .penable (penable),
         .pwrite  (req_q.write),
         .offset  (req_q.addr[OFF_WIDTH-1:0]),
         .pwdata  (req_q.wdata),
         .prdata  (slv_prdata[gi]),
         .pready  (slv_pready[gi]),
         .pslverr (slv_pslverr[gi])
      );
   end

   // Unselected slaves drive zero, so an OR-reduction is a valid bus mux.
   always_comb begin
      bus_prdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         bus_prdata = bus_prdata | slv_prdata[i];
      end
   end

   // A missing slave must not hang the master: complete immediately with zero data.
   assign xfer_ready = idx_valid ? (|slv_pready)  : 1'b1;
   assign xfer_rdata = idx_valid ? bus_prdata     : '0;
   assign xfer_err   = idx_valid ? (|slv_pslverr) : SLVERR_OOR;

   always_comb begin
      state_d     = state_q;
      req_d       = req_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (i_req_valid) begin
               req_d.write = i_req_write;
               req_d.addr  = i_req_addr;
               req_d.wdata = i_req_wdata;
               state_d     = SETUP;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (xfer_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = req_q.write ? '0 : xfer_rdata;
               rsp_err_d   = xfer_err;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
      if (!i_PRESETn) begin
         state_q     <= IDLE;
         req_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign o_req_ready = (state_q == IDLE);
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_rdata = rsp_rdata_q;
   assign o_rsp_err   = rsp_err_q;
   assign o_PADDR     = req_q.addr;
   assign o_PWRITE    = req_q.write;
   assign o_PWDATA    = req_q.wdata;
   assign o_PENABLE   = penable;
   assign o_PSEL      = psel;
   assign o_PRDATA    = bus_prdata;
   assign o_PREADY    = |slv_pready;

endmodule

`default_nettype wire

// File: tb/tb_apb_controller_wrapper.sv
// ============================================================================
// Module   : tb_apb_controller_wrapper
// Brief    : Scoreboard bench; instance 0 has no wait states, instance 1 has two.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_controller_wrapper;

`ifdef APB_SLVERR_EN
   localparam logic OOR_ERR = 1'b1;
`else
   localparam logic OOR_ERR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       req_v, req_w, rdy, rv, rerr, pw, pen, prdy;
   logic [1:0][7:0]  req_a, paddr;
   logic [1:0][31:0] req_wd, rdat, pwd, prd;
   logic [1:0][1:0]  psel;

   apb_controller_wrapper #(.WAIT_CYCLES(0)) dut0 (
      .i_PCLK(clk), .i_PRESETn(rst_n),
      .i_req_valid(req_v[0]), .i_req_write(req_w[0]), .i_req_addr(req_a[0]), .i_req_wdata(req_wd[0]),
      .o_req_ready(rdy[0]), .o_rsp_valid(rv[0]), .o_rsp_rdata(rdat[0]), .o_rsp_err(rerr[0]),
      .o_PADDR(paddr[0]), .o_PWRITE(pw[0]), .o_PWDATA(pwd[0]), .o_PENABLE(pen[0]),
      .o_PSEL(psel[0]), .o_PRDATA(prd[0]), .o_PREADY(prdy[0]));

   apb_controller_wrapper #(.WAIT_CYCLES(2)) dut1 (
      .i_PCLK(clk), .i_PRESETn(rst_n),
      .i_req_valid(req_v[1]), .i_req_write(req_w[1]), .i_req_addr(req_a[1]), .i_req_wdata(req_wd[1]),
      .o_req_ready(rdy[1]), .o_rsp_valid(rv[1]), .o_rsp_rdata(rdat[1]), .o_rsp_err(rerr[1]),
      .o_PADDR(paddr[1]), .o_PWRITE(pw[1]), .o_PWDATA(pwd[1]), .o_PENABLE(pen[1]),
      .o_PSEL(psel[1]), .o_PRDATA(prd[1]), .o_PREADY(prdy[1]));

   typedef struct {
      logic [31:0] rd;
      logic        er;
      int          lat;
   } exp_t;

   exp_t sbq[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   // Latency counts negedges from the cycle the request is seen with ready high.
   task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int lat, output int pcnt,
                       output logic to);
      int guard;
      @(negedge clk);
      req_v[d] = 1'b1; req_w[d] = wr; req_a[d] = a; req_wd[d] = wd;
      guard = 0;
      while (!rdy[d] && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      req_v[d] = 1'b0;
      lat = 1; pcnt = 0;
      while (!rv[d] && lat < 40) begin
         if (pen[d]) pcnt++;
         @(negedge clk);
         lat++;
      end
      to = !rv[d];
      rd = rdat[d];
      er = rerr[d];
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (rdy !== 2'b11) begin n_fail++; $display("FAIL reset_ready got=%b want=11", rdy); end
      n_vec++; if (psel !== 4'b0) begin n_fail++; $display("FAIL reset_psel got=%b want=0", psel); end
      n_vec++; if (pen !== 2'b00) begin n_fail++; $display("FAIL reset_penable got=%b want=00", pen); end
      n_vec++; if (rv !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got=%b want=00", rv); end
      rst_n = 1'b1;
   endtask

   task automatic test_write_read;
      logic [31:0] rd; logic er, to; int lat, pc; exp_t e;
      logic        wr_t [3] = '{1'b1, 1'b0, 1'b0};
      logic [7:0]  ad_t [3] = '{8'h03, 8'h03, 8'h05};
      logic [31:0] wd_t [3] = '{32'hDEADBEEF, 32'h0, 32'h0};
      logic [31:0] ex_t [3] = '{32'h0, 32'hDEADBEEF, 32'h0};
      for (int i = 0; i < 3; i++) begin
         sbq.push_back('{rd: ex_t[i], er: 1'b0, lat: 3});
         xfer(0, wr_t[i], ad_t[i], wd_t[i], rd, er, lat, pc, to);
         e = sbq.pop_front();
         n_vec++; if (to) begin n_fail++; $display("FAIL wr_rd_timeout step=%0d", i); end
         n_vec++; if (rd !== e.rd) begin n_fail++; $display("FAIL wr_rd_data step=%0d got=%h want=%h", i, rd, e.rd); end
         n_vec++; if (er !== e.er) begin n_fail++; $display("FAIL wr_rd_err step=%0d got=%b want=%b", i, er, e.er); end
         n_vec++; if (lat !== e.lat) begin n_fail++; $display("FAIL wr_rd_latency step=%0d got=%0d want=%0d", i, lat, e.lat); end
      end
   endtask

   task automatic test_isolation;
      logic [31:0] rd; logic er, to; int lat, pc; exp_t e;
      logic        wr_t [3] = '{1'b1, 1'b0, 1'b0};
      logic [7:0]  ad_t [3] = '{8'h83, 8'h03, 8'h83};
      logic [31:0] wd_t [3] = '{32'h12345678, 32'h0, 32'h0};
      logic [31:0] ex_t [3] = '{32'h0, 32'hDEADBEEF, 32'h12345678};
      for (int i = 0; i < 3; i++) begin
         sbq.push_back('{rd: ex_t[i], er: 1'b0, lat: 3});
         xfer(0, wr_t[i], ad_t[i], wd_t[i], rd, er, lat, pc, to);
         e = sbq.pop_front();
         n_vec++; if (to || rd !== e.rd) begin n_fail++; $display("FAIL isolation_data step=%0d got=%h want=%h", i, rd, e.rd); end
         n_vec++; if (er !== e.er) begin n_fail++; $display("FAIL isolation_err step=%0d got=%b want=%b", i, er, e.er); end
      end
   endtask

   task automatic test_wait_states;
      logic [31:0] rd; logic er, to; int lat, pc; exp_t e;
      logic        wr_t [2] = '{1'b1, 1'b0};
      logic [31:0] ex_t [2] = '{32'h0, 32'hA5A5_5A5A};
      for (int i = 0; i < 2; i++) begin
         sbq.push_back('{rd: ex_t[i], er: 1'b0, lat: 5});
         xfer(1, wr_t[i], 8'h85, 32'hA5A5_5A5A, rd, er, lat, pc, to);
         e = sbq.pop_front();
         n_vec++; if (to || rd !== e.rd) begin n_fail++; $display("FAIL wait_data step=%0d got=%h want=%h", i, rd, e.rd); end
         n_vec++; if (lat !== e.lat) begin n_fail++; $display("FAIL wait_latency step=%0d got=%0d want=%0d", i, lat, e.lat); end
         n_vec++; if (pc !== 3) begin n_fail++; $display("FAIL wait_penable_cycles step=%0d got=%0d want=3", i, pc); end
      end
   endtask

   // Fills slave 1 through its last word, then probes one word past the end.
   task automatic test_back_to_back;
      logic [31:0] rd; logic er, to; int lat, pc; exp_t e;
      logic [31:0] model [17];
      for (int i = 0; i < 17; i++) begin
         model[i] = $urandom;
         sbq.push_back('{rd: 32'h0, er: (i == 16) ? OOR_ERR : 1'b0, lat: 3});
         xfer(0, 1'b1, 8'h80 | 8'(i), model[i], rd, er, lat, pc, to);
         e = sbq.pop_front();
         n_vec++; if (to || rd !== e.rd || er !== e.er) begin n_fail++; $display("FAIL sweep_write word=%0d got=%h/%b want=%h/%b", i, rd, er, e.rd, e.er); end
      end
      model[16] = 32'h0;
      for (int i = 0; i < 17; i++) begin
         sbq.push_back('{rd: model[i], er: (i == 16) ? OOR_ERR : 1'b0, lat: 3});
         xfer(0, 1'b0, 8'h80 | 8'(i), 32'h0, rd, er, lat, pc, to);
         e = sbq.pop_front();
         n_vec++; if (to || rd !== e.rd || er !== e.er || lat !== e.lat) begin n_fail++; $display("FAIL sweep_read word=%0d got=%h/%b/%0d want=%h/%b/%0d", i, rd, er, lat, e.rd, e.er, e.lat); end
      end
   endtask

   task automatic test_out_of_range;
      logic [31:0] rd; logic er, to; int lat, pc; exp_t e;
      logic        wr_t [3] = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         sbq.push_back('{rd: 32'h0, er: OOR_ERR, lat: 3});
         xfer(0, wr_t[i], 8'h1F, 32'hFFFF_FFFF, rd, er, lat, pc, to);
         e = sbq.pop_front();
         n_vec++; if (to || rd !== e.rd) begin n_fail++; $display("FAIL oor_data step=%0d got=%h want=%h", i, rd, e.rd); end
         n_vec++; if (er !== e.er) begin n_fail++; $display("FAIL oor_err step=%0d got=%b want=%b", i, er, e.er); end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd; logic er, to; int lat, pc, guard; logic seen; exp_t e;
      @(negedge clk);
      req_v[0] = 1'b1; req_w[0] = 1'b1; req_a[0] = 8'h03; req_wd[0] = 32'h5555_AAAA;
      @(negedge clk);
      req_v[0] = 1'b0;
      guard = 0;
      while (!pen[0] && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      n_vec++; if (!pen[0]) begin n_fail++; $display("FAIL midrst_access_reached got=%b want=1", pen[0]); end
      rst_n = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         #1 seen = seen | rv[0];
         @(negedge clk);
      end
      n_vec++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rsp got=%b want=0", seen); end
      n_vec++; if (rdy[0] !== 1'b1 || psel[0] !== 2'b00 || pen[0] !== 1'b0) begin n_fail++; $display("FAIL midrst_bus_idle got=%b/%b/%b want=1/00/0", rdy[0], psel[0], pen[0]); end
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sbq.push_back('{rd: 32'h0, er: 1'b0, lat: 3});
         xfer(0, 1'b0, (i == 0) ? 8'h03 : 8'h83, 32'h0, rd, er, lat, pc, to);
         e = sbq.pop_front();
         n_vec++; if (to || rd !== e.rd) begin n_fail++; $display("FAIL midrst_cleared step=%0d got=%h want=%h", i, rd, e.rd); end
      end
   endtask

   initial begin
      req_v = '0; req_w = '0; req_a = '0; req_wd = '0;
      test_reset;
      test_write_read;
      test_isolation;
      test_wait_states;
      test_out_of_range;
      test_back_to_back;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
